transceiver_tlp_channel_arbiter: RTL
====================================

Name: transceiver_tlp_channel_arbiter

Overview:
Parametrised N-channel TLP multiplexer in front of the transmitter packet interface TLP write port, running in the 120 MHz system domain. Each channel has a 2-entry FIFO. Selection is round-robin with bounded bursts or fixed priority. Each forwarded TLP carries its channel id, and a watchdog flags when the transmitter has stalled.

Parameters:
NUM_CH, 4, number of TLP source channels (2..16)
TLP_WIDTH, 64, payload width per channel
CH_ID_WIDTH, 2, channel id width; must be >= clog2(NUM_CH)
ARB_MODE, 0, 0 = round-robin with burst, 1 = fixed priority (ch0 highest)
MAX_BURST, 4, max consecutive grants to one channel in RR mode (1..255)
STALL_TIMEOUT, 255, blocked cycles before o_stall asserts (1..65535)

Ports:
i_sys_clk_120  in  1  system clock; the only clock
i_sys_rst  in  1  synchronous reset, active-high
i_ch_tlp_wr  in  NUM_CH  per-channel write strobe
i_ch_tlp  in  NUM_CH*TLP_WIDTH  channel k payload at bits [k*TLP_WIDTH +: TLP_WIDTH]
o_ch_tlp_rdy  out  NUM_CH  registered; channel FIFO has a free slot
i_ch_en  in  NUM_CH  channel k takes part in arbitration when 1
o_ch_overflow  out  NUM_CH  sticky; a write arrived while the FIFO was full
i_tlp_rdy  in  1  downstream (transmitter) accepts a TLP this cycle
o_tlp_wr  out  1  registered one-cycle write strobe to the transmitter
o_tlp  out  CH_ID_WIDTH+TLP_WIDTH  {channel id, payload}; valid while o_tlp_wr=1
o_grant_ch  out  CH_ID_WIDTH  id of the most recently granted channel
o_stall  out  1  watchdog flag

Behaviour:
- Clocking and reset: single clock i_sys_clk_120. Reset is synchronous and active-high on i_sys_rst; no other clock or asynchronous reset exists.
- Reset values:
  - All FIFOs are flushed; pending entries are lost.
  - o_ch_tlp_rdy = all 1 from the first cycle after reset.
  - o_tlp_wr = 0, o_tlp = 0, o_grant_ch = 0, o_stall = 0, o_ch_overflow = 0.
  - RR pointer = NUM_CH-1, so ch0 wins first; burst_cnt = 0; watchdog count = 0.
- Channel FIFO:
  - 2 entries per channel, count 0..2.
  - Push occurs when i_ch_tlp_wr[k] & o_ch_tlp_rdy[k].
  - o_ch_tlp_rdy[k] = (count_next < 2), registered.
  - Push and pop on the same channel in the same cycle: both happen, count unchanged, data order preserved.
  - Write while count = 2 (rdy = 0): data dropped, o_ch_overflow[k] set until reset.
- Eligibility: channel k is eligible when count[k] > 0 and i_ch_en[k] = 1.
  - A disabled channel keeps its entries and its rdy handshake.
  - Its entries are forwarded once it is re-enabled.
- Pop: one per cycle, only when i_tlp_rdy = 1 and at least one channel is eligible.
  - On the next edge: o_tlp_wr = 1, o_tlp = {k, FIFO head}, o_grant_ch = k.
  - Otherwise o_tlp_wr = 0 and o_tlp holds its last value.
- Latency: write in cycle n, with an empty FIFO and idle arbitration, gives o_tlp_wr = 1 in cycle n+2.
- Throughput: one TLP per cycle aggregate; a single channel can sustain one per cycle.
- Fixed priority (ARB_MODE = 1): lowest-index eligible channel wins; burst logic is inactive.
- Round-robin (ARB_MODE = 0), with g = last granted channel:
  - If g is eligible and burst_cnt < MAX_BURST: grant g, burst_cnt++.
  - Otherwise: grant the first eligible channel scanning g+1, g+2, ... cyclically (g may win again if it is the only eligible one); burst_cnt = 1.
  - Pointer and burst_cnt update only on a pop; cycles with i_tlp_rdy = 0 freeze them.
- Watchdog:
  - Counter increments on each cycle with i_tlp_rdy = 0 and any channel eligible; it saturates at STALL_TIMEOUT.
  - o_stall = 1 while counter = STALL_TIMEOUT.
  - Counter and o_stall clear on the cycle after a pop.
  - Cycles with nothing eligible hold the counter.
- Reset mid-operation: a synchronous reset wins over simultaneous push/pop; no output strobe is produced in the reset cycle or the cycle after.
- Widths: o_tlp id field is the zero-extended channel index.

Test Plan:
- Single write: ch2 writes 0xA5 in cycle 0 with i_tlp_rdy = 1 -> o_tlp_wr = 1 in cycle 2 with o_tlp = {2, 0xA5}; o_ch_tlp_rdy[2] stays 1.
- RR burst: NUM_CH = 4, MAX_BURST = 2, all channels hold 2 entries, i_tlp_rdy = 1 -> grant order 0,0,1,1,2,2,3,3, eight consecutive o_tlp_wr pulses.
- Fixed priority: ARB_MODE = 1, ch1 and ch3 each keep refilling every cycle -> only ch1 is granted; ch3 drains only after ch1 stops.
- Backpressure and overflow: i_tlp_rdy = 0, ch0 writes 3 TLPs -> rdy[0] drops after the 2nd, o_ch_overflow[0] = 1; on release, exactly the first 2 TLPs emerge in order.
- Watchdog: STALL_TIMEOUT = 10, one entry pending, i_tlp_rdy = 0 -> o_stall = 1 after 10 blocked cycles; i_tlp_rdy = 1 -> pop, then o_stall = 0 the cycle after.
- Disable and reset: i_ch_en[1] = 0 with 2 entries queued -> no ch1 grants, rdy[1] = 0; assert i_sys_rst mid-stream -> all rdy = 1, o_tlp_wr = 0, queued data never appears.

Source files
------------

// File: rtl/transceiver_tlp_channel_arbiter_if.sv
// Bundle of the per-channel TLP source ports and the merged transmitter write port.
// The arbiter connects through the slave modport; a TLP source/sink model uses the master modport.
interface transceiver_tlp_channel_arbiter_if #(
   parameter int NUM_CH      = 4,
   parameter int TLP_WIDTH   = 64,
   parameter int CH_ID_WIDTH = 2
);
   logic [NUM_CH-1:0]                i_ch_tlp_wr;
   logic [NUM_CH*TLP_WIDTH-1:0]      i_ch_tlp;
   logic [NUM_CH-1:0]                o_ch_tlp_rdy;
   logic [NUM_CH-1:0]                i_ch_en;
   logic [NUM_CH-1:0]                o_ch_overflow;
   logic                             i_tlp_rdy;
   logic                             o_tlp_wr;
   logic [CH_ID_WIDTH+TLP_WIDTH-1:0] o_tlp;
   logic [CH_ID_WIDTH-1:0]           o_grant_ch;
   logic                             o_stall;

   modport master (
      output i_ch_tlp_wr, i_ch_tlp, i_ch_en, i_tlp_rdy,
      input  o_ch_tlp_rdy, o_ch_overflow, o_tlp_wr, o_tlp, o_grant_ch, o_stall
   );

   modport slave (
      input  i_ch_tlp_wr, i_ch_tlp, i_ch_en, i_tlp_rdy,
      output o_ch_tlp_rdy, o_ch_overflow, o_tlp_wr, o_tlp, o_grant_ch, o_stall
   );
endinterface

// File: rtl/transceiver_tlp_channel_arbiter.sv
// N-channel TLP multiplexer: a 2-entry FIFO per channel, round-robin-with-burst or fixed-priority
// selection onto one registered transmitter write port, and a watchdog for a stalled transmitter.
module transceiver_tlp_channel_arbiter #(
   parameter int NUM_CH        = 4,
   parameter int TLP_WIDTH     = 64,
   parameter int CH_ID_WIDTH   = 2,
   parameter int ARB_MODE      = 0,
   parameter int MAX_BURST     = 4,
   parameter int STALL_TIMEOUT = 255
) (
   input  logic                            i_sys_clk_120,
   input  logic                            i_sys_rst,
   transceiver_tlp_channel_arbiter_if.slave bus
);
   localparam logic [7:0]  MAX_BURST_L = 8'(MAX_BURST);
   localparam logic [15:0] STALL_L     = 16'(STALL_TIMEOUT);

   logic [NUM_CH-1:0]                eligible;
   logic [NUM_CH-1:0]                rdy_vec;
   logic [NUM_CH-1:0]                ovf_vec;
   logic [TLP_WIDTH-1:0]             head_or [NUM_CH+1];

   logic                             grant_valid;
   logic [CH_ID_WIDTH-1:0]           grant_idx;
   logic                             grant_cont;
   logic                             pop;
   logic [TLP_WIDTH-1:0]             head_sel;

   logic [CH_ID_WIDTH-1:0]           ptr_reg;
   logic [7:0]                       burst_reg;
   logic [7:0]                       burst_next;
   logic [15:0]                      wd_reg;
   logic [15:0]                      wd_next;
   logic                             stall_reg;
   logic                             stall_next;
   logic                             tlp_wr_reg;
   logic [CH_ID_WIDTH+TLP_WIDTH-1:0] tlp_reg;
   logic [CH_ID_WIDTH-1:0]           grant_reg;

   assign head_or[0] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [TLP_WIDTH-1:0] mem_reg [2];
         logic [1:0]           count_reg;
         logic [1:0]           count_next;
         logic                 wr_ptr_reg;
         logic                 rd_ptr_reg;
         logic                 rdy_reg;
         logic                 ovf_reg;
         logic                 push;
         logic                 ch_sel;
         logic                 ch_pop;

         // rdy is registered, so a push is only ever accepted into a free slot.
         assign push   = bus.i_ch_tlp_wr[gi] & rdy_reg;
         assign ch_sel = (grant_idx == CH_ID_WIDTH'(gi));
         assign ch_pop = pop & ch_sel;

         always_comb begin
            count_next = count_reg;
            if (push && !ch_pop) begin
               count_next = count_reg + 2'd1;
            end else if (!push && ch_pop) begin
               count_next = count_reg - 2'd1;
            end
         end

         always_ff @(posedge i_sys_clk_120) begin
            if (i_sys_rst) begin
               count_reg  <= 2'd0;
               wr_ptr_reg <= 1'b0;
               rd_ptr_reg <= 1'b0;
               rdy_reg    <= 1'b1;
               ovf_reg    <= 1'b0;
            end else begin
               count_reg <= count_next;
               rdy_reg   <= (count_next < 2'd2);
               if (push) begin
                  mem_reg[wr_ptr_reg] <= bus.i_ch_tlp[gi*TLP_WIDTH +: TLP_WIDTH];
                  wr_ptr_reg          <= ~wr_ptr_reg;
               end
               if (ch_pop) begin
                  rd_ptr_reg <= ~rd_ptr_reg;
               end
               if (bus.i_ch_tlp_wr[gi] && !rdy_reg) begin
                  ovf_reg <= 1'b1;
               end
            end
         end

         assign eligible[gi]  = (count_reg != 2'd0) & bus.i_ch_en[gi];
         assign rdy_vec[gi]   = rdy_reg;
         assign ovf_vec[gi]   = ovf_reg;
         assign head_or[gi+1] = head_or[gi] | (ch_sel ? mem_reg[rd_ptr_reg] : '0);
      end
   endgenerate

   assign head_sel = head_or[NUM_CH];

   // Candidate selection. In round-robin mode the scan runs from the highest offset down so the
   // nearest eligible channel after the pointer is the last (winning) assignment; offset NUM_CH
   // is the pointer channel itself, which wins only when nothing else is eligible.
   always_comb begin
      logic [NUM_CH-1:0] sel;
      int                idx;
      sel         = '0;
      idx         = 0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_cont  = 1'b0;
      if (ARB_MODE == 1) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            sel = eligible >> i;
            if (sel[0]) begin
               grant_valid = 1'b1;
               grant_idx   = CH_ID_WIDTH'(i);
            end
         end
      end else begin
         sel = eligible >> ptr_reg;
         // burst_reg = 0 means no burst is open yet, so ch0 wins the first grant after reset.
         if (sel[0] && (burst_reg != 8'd0) && (burst_reg < MAX_BURST_L)) begin
            grant_valid = 1'b1;
            grant_idx   = ptr_reg;
            grant_cont  = 1'b1;
         end else begin
            for (int i = NUM_CH; i >= 1; i--) begin
               idx = int'(ptr_reg) + i;
               if (idx >= NUM_CH) begin
                  idx = idx - NUM_CH;
               end
               sel = eligible >> idx;
               if (sel[0]) begin
                  grant_valid = 1'b1;
                  grant_idx   = CH_ID_WIDTH'(idx);
               end
            end
         end
      end
   end

   assign pop        = grant_valid & bus.i_tlp_rdy;
   assign burst_next = grant_cont ? (burst_reg + 8'd1) : 8'd1;

   // Watchdog: counts blocked cycles with work pending, saturates, clears on a pop.
   always_comb begin
      wd_next    = wd_reg;
      stall_next = stall_reg;
      if (pop) begin
         wd_next    = '0;
         stall_next = 1'b0;
      end else if (!bus.i_tlp_rdy && (eligible != '0)) begin
         if (wd_reg != STALL_L) begin
            wd_next = wd_reg + 16'd1;
         end
         stall_next = (wd_next == STALL_L);
      end
   end

   always_ff @(posedge i_sys_clk_120) begin
      if (i_sys_rst) begin
         tlp_wr_reg <= 1'b0;
         tlp_reg    <= '0;
         grant_reg  <= '0;
         ptr_reg    <= CH_ID_WIDTH'(NUM_CH - 1);
         burst_reg  <= 8'd0;
         wd_reg     <= 16'd0;
         stall_reg  <= 1'b0;
      end else begin
         tlp_wr_reg <= pop;
         if (pop) begin
            tlp_reg   <= {grant_idx, head_sel};
            grant_reg <= grant_idx;
            ptr_reg   <= grant_idx;
            burst_reg <= burst_next;
         end
         wd_reg    <= wd_next;
         stall_reg <= stall_next;
      end
   end

   assign bus.o_ch_tlp_rdy  = rdy_vec;
   assign bus.o_ch_overflow = ovf_vec;
   assign bus.o_tlp_wr      = tlp_wr_reg;
   assign bus.o_tlp         = tlp_reg;
   assign bus.o_grant_ch    = grant_reg;
   assign bus.o_stall       = stall_reg;
endmodule
